program_loader: RTL and testbench

Byte-stream instruction-memory writer that fills the core's instruction memory before release from reset, replacing hex-file preload for hardware bring-up. It sits between a host byte link (UART receiver or bench driver) and the write port of the instruction memory. It holds `core_reset` asserted until a complete, valid image has been written, then releases the single-cycle core so it starts fetching at PC 0.

---
 rtl/program_loader_pkg.sv | 22 ++
 rtl/program_loader_word_assembler.sv | 37 +++
 rtl/program_loader.sv | 140 ++++++++++++++
 tb/tb_program_loader.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/program_loader_pkg.sv
// Shared types and constants for the program loader (package loader_pkg).
// Optional checksum support is selected by PROGRAM_LOADER_CHECKSUM_EN.
package loader_pkg;

    localparam int unsigned LANES     = 4;
    localparam int unsigned HDR_BYTES = 2;

    typedef enum logic [2:0] {
        HDR_LO,
        HDR_HI,
        DATA,
        CHK,
        FIN,
        DONE,
        ERR
    } state_t;

    function automatic logic is_rx_state(input state_t s);
        return (s == HDR_LO) || (s == HDR_HI) || (s == DATA) || (s == CHK);
    endfunction

endpackage

// File: rtl/program_loader_word_assembler.sv
// Packs four little-endian bytes into a 32-bit word; word_valid is combinational
// on the fourth byte so the caller can register the write on that same edge.
module loader_word_assembler
    import loader_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        word_valid,
    output logic [31:0] word
);

    localparam int unsigned LANE_W = $clog2(LANES);

    logic [LANE_W-1:0]      lane;
    logic [8*(LANES-1)-1:0] shreg;

    // Only the first three lanes are stored; the fourth is taken straight from the input.
    assign word_valid = byte_valid && (lane == LANE_W'(LANES - 1));
    assign word       = {byte_data, shreg};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lane  <= '0;
            shreg <= '0;
        end else if (clear) begin
            lane  <= '0;
            shreg <= '0;
        end else if (byte_valid) begin
            lane  <= lane + 1'b1;
            shreg <= {byte_data, shreg[8*(LANES-1)-1:8]};
        end
    end

endmodule

// File: rtl/program_loader.sv
// Byte-stream instruction memory loader; holds the core in reset until a valid image lands.
// Define PROGRAM_LOADER_CHECKSUM_EN to require a trailing XOR checksum byte.
module program_loader
    import loader_pkg::*;
#(
    parameter int unsigned IMEM_SIZE = 16,
    parameter int unsigned ADDR_W    = $clog2(IMEM_SIZE)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    input  logic              start,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_waddr,
    output logic [31:0]       imem_wdata,
    output logic              core_reset,
    output logic              load_done,
    output logic              load_error
);

    state_t                       state;
    state_t                       state_nxt;
    logic                         fire;
    logic                         restart;
    logic                         asm_valid;
    logic [31:0]                  asm_word;
    logic [8*(HDR_BYTES-1)-1:0]   cnt_lo;
    logic [8*HDR_BYTES-1:0]       hdr_n;
    logic [ADDR_W:0]              count;
    logic [ADDR_W:0]              word_idx;
    logic                         last_word;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    logic [7:0]                   csum;
`endif

    assign fire      = rx_valid && rx_ready;
    assign restart   = start && ((state == DONE) || (state == ERR));
    assign hdr_n     = {rx_data, cnt_lo};
    assign last_word = (word_idx == count - 1'b1);

    loader_word_assembler u_asm (
        .clk        (clk),
        .reset      (reset),
        .clear      (restart),
        .byte_valid (fire && (state == DATA)),
        .byte_data  (rx_data),
        .word_valid (asm_valid),
        .word       (asm_word)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            HDR_LO: if (fire) state_nxt = HDR_HI;
            HDR_HI: begin
                if (fire) begin
                    if (hdr_n == '0)
                        state_nxt = FIN;
                    else if (hdr_n > 16'(IMEM_SIZE))
                        state_nxt = ERR;
                    else
                        state_nxt = DATA;
                end
            end
            DATA: begin
                if (asm_valid && last_word) begin
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                    state_nxt = CHK;
`else
                    state_nxt = FIN;
`endif
                end
            end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            CHK: if (fire) state_nxt = (rx_data == csum) ? DONE : ERR;
`endif
            FIN:  state_nxt = DONE;
            DONE: if (start) state_nxt = HDR_LO;
            ERR:  if (start) state_nxt = HDR_LO;
            default: state_nxt = HDR_LO;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= HDR_LO;
            rx_ready   <= 1'b1;
            imem_we    <= 1'b0;
            imem_waddr <= '0;
            imem_wdata <= '0;
            core_reset <= 1'b1;
            load_done  <= 1'b0;
            load_error <= 1'b0;
            cnt_lo     <= '0;
            count      <= '0;
            word_idx   <= '0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            csum       <= '0;
`endif
        end else begin
            state    <= state_nxt;
            rx_ready <= is_rx_state(state_nxt);
            imem_we  <= asm_valid;

            if (asm_valid) begin
                imem_waddr <= word_idx[ADDR_W-1:0];
                imem_wdata <= asm_word;
                word_idx   <= word_idx + 1'b1;
            end

            if (fire && (state == HDR_LO))
                cnt_lo <= rx_data;
            if (fire && (state == HDR_HI))
                count <= hdr_n[ADDR_W:0];

`ifdef PROGRAM_LOADER_CHECKSUM_EN
            if (fire && ((state == HDR_LO) || (state == HDR_HI) || (state == DATA)))
                csum <= csum ^ rx_data;
`endif

            // Status follows the state one edge late, except re-arm which clears it at once.
            if (restart) begin
                word_idx   <= '0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                csum       <= '0;
`endif
                core_reset <= 1'b1;
                load_done  <= 1'b0;
                load_error <= 1'b0;
            end else begin
                core_reset <= (state != DONE);
                load_done  <= (state == DONE);
                load_error <= (state == ERR);
            end
        end
    end

endmodule

// File: tb/tb_program_loader.sv
// Randomized self-checking bench for program_loader; builds the byte stream and
// expected writes/status from the image, honouring PROGRAM_LOADER_CHECKSUM_EN.
module tb_program_loader;

    localparam int unsigned IMEM_SIZE = 16;
    localparam int unsigned ADDR_W    = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic [7:0]        rx_data;
    logic              rx_valid;
    logic              rx_ready;
    logic              start;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_waddr;
    logic [31:0]       imem_wdata;
    logic              core_reset;
    logic              load_done;
    logic              load_error;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    logic [31:0]       img [IMEM_SIZE];
    logic [ADDR_W-1:0] obs_a [$];
    logic [31:0]       obs_d [$];

    always #5 clk = ~clk;

    program_loader #(.IMEM_SIZE(IMEM_SIZE), .ADDR_W(ADDR_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .start      (start),
        .imem_we    (imem_we),
        .imem_waddr (imem_waddr),
        .imem_wdata (imem_wdata),
        .core_reset (core_reset),
        .load_done  (load_done),
        .load_error (load_error)
    );

    always @(negedge clk) begin
        if (reset && imem_we) begin
            obs_a.push_back(imem_waddr);
            obs_d.push_back(imem_wdata);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input int unsigned gap);
        int unsigned waited;
        for (int unsigned g = 0; g < gap; g++) begin
            @(negedge clk);
            rx_valid = 1'b0;
        end
        @(negedge clk);
        rx_valid = 1'b1;
        rx_data  = b;
        waited   = 0;
        while (!rx_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (!rx_ready)
            check("rx_ready_timeout", {31'd0, rx_ready}, 32'd1);
    endtask

    task automatic check_reset_values(input string pfx);
        check({pfx, "_rx_ready"},   {31'd0, rx_ready},   32'd1);
        check({pfx, "_imem_we"},    {31'd0, imem_we},    32'd0);
        check({pfx, "_imem_waddr"}, 32'(imem_waddr),     32'd0);
        check({pfx, "_imem_wdata"}, imem_wdata,          32'd0);
        check({pfx, "_core_reset"}, {31'd0, core_reset}, 32'd1);
        check({pfx, "_load_done"},  {31'd0, load_done},  32'd0);
        check({pfx, "_load_error"}, {31'd0, load_error}, 32'd0);
    endtask

    task automatic restart();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("rearm_rx_ready",   {31'd0, rx_ready},   32'd1);
        check("rearm_core_reset", {31'd0, core_reset}, 32'd1);
        check("rearm_load_done",  {31'd0, load_done},  32'd0);
        check("rearm_load_error", {31'd0, load_error}, 32'd0);
    endtask

    // Streams an image of n words from img[], then checks release timing, status and writes.
    task automatic run_load(input int unsigned n, input int unsigned max_gap, input bit corrupt);
        logic [7:0]  q [$];
        logic [7:0]  x;
        bit          chk_byte;
        bit          exp_err;
        int unsigned lat;
        int unsigned exp_w;
        logic [15:0] n16;

        obs_a.delete();
        obs_d.delete();
        n16 = 16'(n);
        q.push_back(n16[7:0]);
        q.push_back(n16[15:8]);
        if (n <= IMEM_SIZE)
            for (int unsigned i = 0; i < n; i++)
                for (int unsigned l = 0; l < 4; l++)
                    q.push_back(8'(img[i] >> (8 * l)));
        x = 8'h00;
        foreach (q[i]) x ^= q[i];
        chk_byte = 1'b0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        if (n >= 1 && n <= IMEM_SIZE) begin
            chk_byte = 1'b1;
            q.push_back(corrupt ? (x ^ 8'hFF) : x);
        end
`endif
        exp_err = (n > IMEM_SIZE) || (chk_byte && corrupt);
        exp_w   = (n <= IMEM_SIZE) ? n : 0;

        foreach (q[i]) send_byte(q[i], (max_gap == 0) ? 0 : $urandom_range(0, max_gap));

        if (!exp_err) begin
            lat = chk_byte ? 1 : 2;
            for (int unsigned k = 0; k <= lat; k++) begin
                @(negedge clk);
                rx_valid = 1'b0;
                if (k == 0 && !chk_byte)
                    check("we_after_last_byte", {31'd0, imem_we}, (n > 0) ? 32'd1 : 32'd0);
                check($sformatf("core_reset_edge%0d", k), {31'd0, core_reset}, (k < lat) ? 32'd1 : 32'd0);
            end
            check("done_load_done",  {31'd0, load_done},  32'd1);
            check("done_load_error", {31'd0, load_error}, 32'd0);
            check("done_rx_ready",   {31'd0, rx_ready},   32'd0);
        end else begin
            @(negedge clk);
            rx_valid = 1'b0;
            check("err_rx_ready_now", {31'd0, rx_ready}, 32'd0);
            repeat (2) @(negedge clk);
            check("err_load_error", {31'd0, load_error}, 32'd1);
            check("err_load_done",  {31'd0, load_done},  32'd0);
            check("err_core_reset", {31'd0, core_reset}, 32'd1);
            check("err_rx_ready",   {31'd0, rx_ready},   32'd0);
        end

        check("write_count", 32'(obs_a.size()), 32'(exp_w));
        for (int unsigned i = 0; i < exp_w && i < obs_a.size(); i++) begin
            check($sformatf("waddr%0d", i), 32'(obs_a[i]), i);
            check($sformatf("wdata%0d", i), obs_d[i], img[i]);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned n;
        reset    = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        start    = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_values("rst");
        reset = 1'b1;
        @(negedge clk);

        img[0] = 32'h00400413;
        img[1] = 32'h00C00493;
        img[2] = 32'h00940933;
        run_load(3, 0, 1'b0);
        restart();
        run_load(3, 5, 1'b0);
        restart();
        run_load(17, 0, 1'b0);
        restart();
        run_load(0, 0, 1'b0);
        restart();

`ifdef PROGRAM_LOADER_CHECKSUM_EN
        img[0] = 32'h00000013;
        run_load(1, 0, 1'b0);
        restart();
        run_load(1, 0, 1'b1);
        restart();
        run_load(1, 3, 1'b0);
        restart();
`endif

        for (int t = 0; t < 6; t++) begin
            n = $urandom_range(1, IMEM_SIZE);
            for (int unsigned i = 0; i < IMEM_SIZE; i++) img[i] = $urandom;
            run_load(n, $urandom_range(0, 3), 1'b0);
            restart();
        end

        for (int unsigned i = 0; i < IMEM_SIZE; i++) img[i] = $urandom;
        send_byte(8'd4, 0);
        send_byte(8'd0, 0);
        for (int unsigned b = 0; b < 6; b++) send_byte(8'(img[b / 4] >> (8 * (b % 4))), 0);
        @(negedge clk);
        reset    = 1'b0;
        rx_valid = 1'b0;
        #1;
        check_reset_values("midrst");
        repeat (2) @(negedge clk);
        reset = 1'b1;
        run_load(4, 2, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
